// File: rtl/dbg_responder.sv
// -----------------------------------------------------------------------------
// dbg_responder
//   CPU-side end of the debug interface.
//   - Turns the debug run request into a registered CPU clock-enable.
//   - Registers the register-file debug read data (address = m_rf_addr LSBs).
//   - Reads data memory at the debug address through a req/ack port that the
//     CPU datapath has priority on. It re-reads on address change and on an
//     idle refresh interval. It aborts a read that gets no ack within TIMEOUT
//     cycles.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_run             level run request (1-cycle pulse = single step)
//   i_m_rf_addr       debug address for memory and register-file reads
//   o_cpu_en          registered CPU clock-enable
//   o_halted          ~o_cpu_en
//   o_rf_raddr        register-file read address (combinational)
//   i_rf_rdata        register-file read data (same cycle)
//   o_rf_data         registered register-file data
//   i_cpu_mem_busy    CPU owns the memory port this cycle
//   o_mem_req         debug memory read request
//   o_mem_addr        debug memory read address
//   i_mem_ack         1-cycle ack, i_mem_rdata valid in the same cycle
//   i_mem_rdata       memory read data
//   o_m_data          last memory read result
//   o_m_valid         o_m_data belongs to the current i_m_rf_addr
//   o_m_err           last memory read timed out
// -----------------------------------------------------------------------------
module dbg_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int REFRESH = 1023,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_m_rf_addr,
  output logic              o_cpu_en,
  output logic              o_halted,
  output logic [RF_AW-1:0]  o_rf_raddr,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic [DATA_W-1:0] o_rf_data,
  input  logic              i_cpu_mem_busy,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  output logic              o_m_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int RC_W = $clog2(REFRESH + 1);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PORT = 2'd1,
    REQ       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_q;     // address of the last issued request
  logic [RC_W-1:0]   r_ref_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_pending;    // address moved while a read was in flight
  logic              r_cpu_en;
  logic [DATA_W-1:0] r_rf_data;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_m_err;

  logic w_addr_diff;
  logic w_ref_hit;
  logic w_chg;

  assign w_addr_diff = (i_m_rf_addr != r_addr_q);
  assign w_ref_hit   = (r_ref_cnt == RC_W'(REFRESH));
  assign w_chg       = w_addr_diff | w_ref_hit;

  assign o_rf_raddr  = i_m_rf_addr[RF_AW-1:0];
  assign o_cpu_en    = r_cpu_en;
  assign o_halted    = ~r_cpu_en;
  assign o_rf_data   = r_rf_data;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_m_data    = r_m_data;
  assign o_m_valid   = r_m_valid;
  assign o_m_err     = r_m_err;

  // Run control, RF data capture and the memory-read FSM with its outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr_q   <= '0;
      r_ref_cnt  <= '0;
      r_to_cnt   <= '0;
      r_pending  <= 1'b0;
      r_cpu_en   <= 1'b0;
      r_rf_data  <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_err    <= 1'b0;
    end else begin
      r_cpu_en  <= i_run;
      r_rf_data <= i_rf_rdata;

      case (r_state)
        IDLE: begin
          // A pending flag forces a reissue even if the address came back.
          if (w_chg || r_pending) begin
            r_addr_q  <= i_m_rf_addr;
            r_m_valid <= 1'b0;
            r_pending <= 1'b0;
            r_ref_cnt <= '0;
            if (i_cpu_mem_busy) begin
              r_state <= WAIT_PORT;
            end else begin
              r_state    <= REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= i_m_rf_addr;
              r_to_cnt   <= '0;
            end
          end else if (!w_ref_hit) begin
            r_ref_cnt <= r_ref_cnt + RC_W'(1);
          end else begin
            r_ref_cnt <= r_ref_cnt;
          end
        end

        WAIT_PORT: begin
          if (w_addr_diff) begin
            r_pending <= 1'b1;
          end
          if (!i_cpu_mem_busy) begin
            r_state    <= REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_addr_q;
            r_to_cnt   <= '0;
          end
        end

        REQ: begin
          // The CPU may grab the port mid-request; the arbiter stalls the
          // ack, so the request stays up and only the timeout ends it.
          if (w_addr_diff) begin
            r_pending <= 1'b1;
          end
          if (i_mem_ack) begin
            r_m_data  <= i_mem_rdata;
            r_m_err   <= 1'b0;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end else if (r_to_cnt >= TO_W'(TIMEOUT - 1)) begin
            r_m_data  <= DATA_W'(TIMEOUT_DATA);
            r_m_err   <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        DONE: begin
          // A mismatch here leaves pending set, so IDLE reissues next cycle.
          r_m_valid <= ~w_addr_diff;
          if (w_addr_diff) begin
            r_pending <= 1'b1;
          end
          r_state <= IDLE;
        end

        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_responder.sv
module tb_dbg_responder;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  m_rf_addr;
  logic        cpu_en;
  logic        halted;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [31:0] rf_data;
  logic        cpu_mem_busy;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_err;

  int checks;
  int errors;

  dbg_responder dut (
    .clk            (clk),
    .rst            (rst),
    .i_run          (run),
    .i_m_rf_addr    (m_rf_addr),
    .o_cpu_en       (cpu_en),
    .o_halted       (halted),
    .o_rf_raddr     (rf_raddr),
    .i_rf_rdata     (rf_rdata),
    .o_rf_data      (rf_data),
    .i_cpu_mem_busy (cpu_mem_busy),
    .o_mem_req      (mem_req),
    .o_mem_addr     (mem_addr),
    .i_mem_ack      (mem_ack),
    .i_mem_rdata    (mem_rdata),
    .o_m_data       (m_data),
    .o_m_valid      (m_valid),
    .o_m_err        (m_err)
  );

  // Register-file stand-in: data is a fixed pattern of the read address.
  assign rf_rdata = 32'hA5A5_0000 | {27'd0, rf_raddr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    run = 1'b0;
    m_rf_addr = 8'h00;
    cpu_mem_busy = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    #12;
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_err", {31'd0, m_err}, 32'd0);
    check("rst_rf_data", rf_data, 32'd0);
    rst = 1'b0;
    tick();

    // Run control: single step, then a 4-cycle run.
    run = 1'b1;
    check("step_same_cycle", {31'd0, cpu_en}, 32'd0);
    tick();
    run = 1'b0;
    check("step_next_cycle", {31'd0, cpu_en}, 32'd1);
    tick();
    check("step_after", {31'd0, cpu_en}, 32'd0);
    n = 0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) run = 1'b0;
      tick();
      if (cpu_en) n++;
    end
    check("run4_count", n, 32'd4);

    // Basic read of 8'h05, ack in the third request cycle.
    m_rf_addr = 8'h05;
    check("rf_raddr", {27'd0, rf_raddr}, 32'd5);
    tick();
    check("rf_data", rf_data, 32'hA5A5_0005);
    check("rd_req_up", {31'd0, mem_req}, 32'd1);
    check("rd_addr_c1", {24'd0, mem_addr}, 32'h05);
    tick();
    check("rd_addr_c2", {24'd0, mem_addr}, 32'h05);
    tick();
    check("rd_req_c3", {31'd0, mem_req}, 32'd1);
    check("rd_addr_c3", {24'd0, mem_addr}, 32'h05);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_1234;
    tick();
    mem_ack = 1'b0;
    check("rd_m_data", m_data, 32'h0000_1234);
    check("rd_m_err", {31'd0, m_err}, 32'd0);
    check("rd_req_down", {31'd0, mem_req}, 32'd0);
    tick();
    check("rd_m_valid", {31'd0, m_valid}, 32'd1);

    // Stray ack while idle must not touch m_data.
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    tick();
    check("stray_ack_data", m_data, 32'h0000_1234);
    check("stray_ack_valid", {31'd0, m_valid}, 32'd1);

    // CPU holds the port for 10 cycles at the address change.
    m_rf_addr = 8'h07;
    cpu_mem_busy = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req) n++;
    end
    check("busy_req_cycles", n, 32'd0);
    cpu_mem_busy = 1'b0;
    tick();
    check("busy_release_req", {31'd0, mem_req}, 32'd1);
    check("busy_release_addr", {24'd0, mem_addr}, 32'h07);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_7777;
    tick();
    mem_ack = 1'b0;
    tick();
    check("busy_m_data", m_data, 32'h0000_7777);
    check("busy_m_valid", {31'd0, m_valid}, 32'd1);

    // No ack: request must drop after 15 cycles with the error pattern.
    m_rf_addr = 8'h0A;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) n++;
      tick();
    end
    check("to_req_cycles", n, 32'd15);
    check("to_m_data", m_data, 32'hDEAD_BEEF);
    check("to_m_err", {31'd0, m_err}, 32'd1);

    // Address moves 05 -> 09 while the 05 request is outstanding.
    m_rf_addr = 8'h05;
    tick();
    check("chg_req_05", {31'd0, mem_req}, 32'd1);
    m_rf_addr = 8'h09;
    tick();
    check("chg_addr_held", {24'd0, mem_addr}, 32'h05);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_5555;
    tick();
    mem_ack = 1'b0;
    check("chg_old_data", m_data, 32'h0000_5555);
    check("chg_old_err", {31'd0, m_err}, 32'd0);
    tick();
    check("chg_valid_low", {31'd0, m_valid}, 32'd0);
    check("chg_req_gap", {31'd0, mem_req}, 32'd0);
    tick();
    check("chg_req_09", {31'd0, mem_req}, 32'd1);
    check("chg_addr_09", {24'd0, mem_addr}, 32'h09);
    check("chg_valid_wait", {31'd0, m_valid}, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_9999;
    tick();
    mem_ack = 1'b0;
    tick();
    check("chg_new_data", m_data, 32'h0000_9999);
    check("chg_new_valid", {31'd0, m_valid}, 32'd1);

    // Asynchronous reset in the middle of a request.
    run = 1'b1;
    m_rf_addr = 8'h0C;
    tick();
    check("rst_pre_req", {31'd0, mem_req}, 32'd1);
    check("rst_pre_cpu_en", {31'd0, cpu_en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_req", {31'd0, mem_req}, 32'd0);
    check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
    check("rst_mid_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_mid_m_data", m_data, 32'd0);
    tick();
    #2;
    rst = 1'b0;
    check("rst_rel_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("rst_rel_issue", {31'd0, mem_req}, 32'd1);
    check("rst_rel_addr", {24'd0, mem_addr}, 32'h0C);
    check("rst_rel_cpu_en", {31'd0, cpu_en}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
